add_normalize: RTL and testbench

ADD_NORMALIZE -- requirements
Module: add_normalize

---
 rtl/fp_pkg.sv | 37 +++
 rtl/round_nearest_even.sv | 55 +++++
 rtl/add_normalize.sv | 210 +++++++++++++++++++++
 tb/tb_add_normalize.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types, constants and helpers for the single-precision add/normalize datapath.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int         BIAS    = 127;
    localparam int         EXP_W   = 8;
    localparam int         EXP_IW  = 9;   // one spare bit so exponent carries saturate instead of wrapping
    localparam int         MANT_W  = 32;
    localparam int         SIG_W   = 24;
    localparam int         FRAC_W  = 23;
    localparam int         GUARD_W = 8;

    function automatic logic [5:0] count_lz(input logic [MANT_W-1:0] value);
        logic [5:0] zeros;
        logic       found;
        zeros = 6'd0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            found = found | value[i];
            if (!found) begin
                zeros = zeros + 6'd1;
            end else begin
                zeros = zeros;
            end
        end
        return zeros;
    endfunction

endpackage

// File: rtl/round_nearest_even.sv
// Combinational round-to-nearest-even of a normalised working mantissa and IEEE-754 packing.
module round_nearest_even
    import fp_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_IW-1:0] exponent,
    input  logic [MANT_W-1:0] mantissa,
    input  logic              sticky,
    output logic [31:0]       result,
    output logic              overflow
);

    logic              guard_s;
    logic              rest_s;
    logic              inc_s;
    logic [SIG_W:0]    sig_s;
    logic [EXP_IW-1:0] exp_s;
    logic [FRAC_W-1:0] frac_s;
    logic              hidden_s;

    // Guard/round/sticky decision and significand increment.
    always_comb begin
        guard_s = mantissa[GUARD_W-1];
        rest_s  = (|mantissa[GUARD_W-2:0]) | sticky;
        inc_s   = guard_s & (rest_s | mantissa[GUARD_W]);
        sig_s   = {1'b0, mantissa[MANT_W-1:GUARD_W]} + {{SIG_W{1'b0}}, inc_s};
    end

    // Carry-out renormalisation, overflow to infinity and subnormal encoding.
    always_comb begin
        exp_s    = exponent;
        frac_s   = sig_s[FRAC_W-1:0];
        hidden_s = sig_s[SIG_W-1];
        result   = 32'h0000_0000;
        overflow = 1'b0;
        if (sig_s[SIG_W]) begin
            exp_s    = exponent + 9'd1;
            frac_s   = {FRAC_W{1'b0}};
            hidden_s = 1'b1;
        end else begin
            exp_s    = exponent;
        end
        if (exp_s >= {1'b0, EXP_MAX}) begin
            result   = {sign, EXP_MAX, {FRAC_W{1'b0}}};
            overflow = 1'b1;
        end else if (!hidden_s) begin
            result   = {sign, 8'h00, frac_s};
            overflow = 1'b0;
        end else begin
            result   = {sign, exp_s[EXP_W-1:0], frac_s};
            overflow = 1'b0;
        end
    end

endmodule

// File: rtl/add_normalize.sv
// Multi-cycle add/subtract of aligned mantissas followed by normalisation and rounding.
module add_normalize
    import fp_pkg::*;
#(
    parameter int NORM_STEP = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        signA,
    input  logic        signB,
    input  logic [7:0]  exponentIn,
    input  logic [31:0] alignedMantissaA,
    input  logic [31:0] alignedMantissaB,
    input  logic        sticky,
    input  logic        shiftOverflow,
    input  logic        bypassALU,
    input  logic [31:0] bypassResult,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow
);

    localparam logic [5:0] STEP = 6'(NORM_STEP);

    state_t              state_r, state_s;
    logic                sign_a_r, sign_a_s;
    logic                sign_b_r, sign_b_s;
    logic                sign_r, sign_s;
    logic [EXP_IW-1:0]   exp_r, exp_s;
    logic [MANT_W-1:0]   mant_a_r, mant_a_s;
    logic [MANT_W-1:0]   mant_b_r, mant_b_s;
    logic [MANT_W-1:0]   mant_r, mant_s;
    logic                sticky_r, sticky_s;
    logic [31:0]         result_r, result_s;
    logic                overflow_r, overflow_s;
    logic                in_ready_r;
    logic                out_valid_r;

    logic [MANT_W:0]     sum_s;
    logic                sum_sign_s;
    logic [5:0]          lz_s;
    logic [5:0]          shift_s;
    logic [EXP_IW-1:0]   exp_room_s;
    logic [MANT_W-1:0]   norm_mant_s;
    logic [EXP_IW-1:0]   norm_exp_s;
    logic [31:0]         rne_result_s;
    logic                rne_overflow_s;

    // Magnitude add, or larger-minus-smaller when signs differ.
    always_comb begin
        sum_s      = {(MANT_W+1){1'b0}};
        sum_sign_s = sign_a_r;
        if (sign_a_r == sign_b_r) begin
            sum_s      = {1'b0, mant_a_r} + {1'b0, mant_b_r};
            sum_sign_s = sign_a_r;
        end else if (mant_a_r >= mant_b_r) begin
            sum_s      = {1'b0, mant_a_r} - {1'b0, mant_b_r};
            sum_sign_s = sign_a_r;
        end else begin
            sum_s      = {1'b0, mant_b_r} - {1'b0, mant_a_r};
            sum_sign_s = sign_b_r;
        end
    end

    // One normalisation step: bounded by NORM_STEP, leading zeros and exponent floor of 1.
    always_comb begin
        lz_s       = count_lz(mant_r);
        exp_room_s = exp_r - 9'd1;
        shift_s    = (lz_s < STEP) ? lz_s : STEP;
        if ({3'b000, shift_s} > exp_room_s) begin
            shift_s = exp_room_s[5:0];
        end else begin
            shift_s = shift_s;
        end
        norm_mant_s = mant_r << shift_s;
        norm_exp_s  = exp_r - {3'b000, shift_s};
    end

    round_nearest_even u_round (
        .sign     (sign_r),
        .exponent (exp_r),
        .mantissa (mant_r),
        .sticky   (sticky_r),
        .result   (rne_result_s),
        .overflow (rne_overflow_s)
    );

    // Next-state and datapath-next logic for the sequencer.
    always_comb begin
        state_s    = state_r;
        sign_a_s   = sign_a_r;
        sign_b_s   = sign_b_r;
        sign_s     = sign_r;
        exp_s      = exp_r;
        mant_a_s   = mant_a_r;
        mant_b_s   = mant_b_r;
        mant_s     = mant_r;
        sticky_s   = sticky_r;
        result_s   = result_r;
        overflow_s = overflow_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_a_s = signA;
                    sign_b_s = signB;
                    exp_s    = {1'b0, exponentIn};
                    mant_a_s = alignedMantissaA;
                    mant_b_s = alignedMantissaB;
                    sticky_s = sticky | shiftOverflow;
                    if (bypassALU) begin
                        result_s   = bypassResult;
                        overflow_s = 1'b0;
                        state_s    = ST_DONE;
                    end else begin
                        state_s    = ST_ADD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if ((sign_a_r != sign_b_r) && (sum_s == 33'd0)) begin
                    result_s   = 32'h0000_0000;
                    overflow_s = 1'b0;
                    state_s    = ST_DONE;
                end else if (sum_s[MANT_W]) begin
                    mant_s   = sum_s[MANT_W:1];
                    sticky_s = sticky_r | sum_s[0];
                    exp_s    = exp_r + 9'd1;
                    sign_s   = sum_sign_s;
                    state_s  = ST_ROUND;
                end else begin
                    mant_s = sum_s[MANT_W-1:0];
                    sign_s = sum_sign_s;
                    if (sum_s[MANT_W-1] || (exp_r <= 9'd1)) begin
                        state_s = ST_ROUND;
                    end else begin
                        state_s = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                mant_s = norm_mant_s;
                exp_s  = norm_exp_s;
                if (norm_mant_s[MANT_W-1] || (norm_exp_s <= 9'd1)) begin
                    state_s = ST_ROUND;
                end else begin
                    state_s = ST_NORM;
                end
            end
            ST_ROUND: begin
                result_s   = rne_result_s;
                overflow_s = rne_overflow_s;
                state_s    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags are registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= 9'd0;
            mant_a_r    <= 32'h0000_0000;
            mant_b_r    <= 32'h0000_0000;
            mant_r      <= 32'h0000_0000;
            sticky_r    <= 1'b0;
            result_r    <= 32'h0000_0000;
            overflow_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sign_a_r    <= sign_a_s;
            sign_b_r    <= sign_b_s;
            sign_r      <= sign_s;
            exp_r       <= exp_s;
            mant_a_r    <= mant_a_s;
            mant_b_r    <= mant_b_s;
            mant_r      <= mant_s;
            sticky_r    <= sticky_s;
            result_r    <= result_s;
            overflow_r  <= overflow_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_add_normalize.sv
// Randomised bench for add_normalize against an arithmetic reference model.
module tb_add_normalize;
    import fp_pkg::*;

    localparam int STEP = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        signA = 1'b0, signB = 1'b0;
    logic [7:0]  exponentIn = 8'h00;
    logic [31:0] alignedMantissaA = 32'h0, alignedMantissaB = 32'h0;
    logic        sticky = 1'b0, shiftOverflow = 1'b0;
    logic        bypassALU = 1'b0;
    logic [31:0] bypassResult = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    add_normalize #(.NORM_STEP(STEP)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .signA(signA), .signB(signB), .exponentIn(exponentIn),
        .alignedMantissaA(alignedMantissaA), .alignedMantissaB(alignedMantissaB),
        .sticky(sticky), .shiftOverflow(shiftOverflow), .bypassALU(bypassALU),
        .bypassResult(bypassResult), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Exact signed sum scaled by 2^(exp-158), normalised and rounded by value.
    task automatic ref_model(input logic sa, input logic sb, input logic [7:0] ex,
                             input logic [31:0] ma, input logic [31:0] mb, input logic stk,
                             input logic byp, input logic [31:0] bres,
                             output logic [31:0] res, output logic ovf, output int lat);
        longint va, vb, tot, mag, sig, rem;
        int e, msb, sh;
        logic s, st, up;
        if (byp) begin
            res = bres; ovf = 1'b0; lat = 1;
            return;
        end
        va  = sa ? -longint'(ma) : longint'(ma);
        vb  = sb ? -longint'(mb) : longint'(mb);
        tot = va + vb;
        if (tot == 0 && sa != sb) begin
            res = 32'h0; ovf = 1'b0; lat = 2;
            return;
        end
        s   = (tot < 0);
        mag = s ? -tot : tot;
        e   = int'(ex);
        st  = stk;
        lat = 3;
        if (mag >= 64'h1_0000_0000) begin
            st  = st | mag[0];
            mag = mag >> 1;
            e   = e + 1;
        end else begin
            msb = -1;
            for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
            sh = 31 - msb;
            if (sh > e - 1) sh = e - 1;
            if (sh < 0) sh = 0;
            mag = mag << sh;
            e   = e - sh;
            lat = lat + (sh + STEP - 1) / STEP;
        end
        sig = mag >> 8;
        rem = mag & 64'hFF;
        up  = (rem > 64'h80) || (rem == 64'h80 && (st || sig[0]));
        if (up) sig = sig + 1;
        if (sig == 64'h100_0000) begin
            sig = 64'h80_0000;
            e   = e + 1;
        end
        if (e >= 255) begin
            res = {s, 8'hFF, 23'h0}; ovf = 1'b1;
        end else if (sig < 64'h80_0000) begin
            res = {s, 8'h00, sig[22:0]}; ovf = 1'b0;
        end else begin
            res = {s, 8'(e), sig[22:0]}; ovf = 1'b0;
        end
    endtask

    task automatic run_txn(input logic sa, input logic sb, input logic [7:0] ex,
                           input logic [31:0] ma, input logic [31:0] mb, input logic stk,
                           input logic sov, input logic byp, input logic [31:0] bres,
                           input int hold, input logic [31:0] want_res,
                           input logic want_ovf, input int want_lat);
        int lat;
        @(negedge clock);
        check_value("in_ready_idle", {31'd0, in_ready}, 32'd1);
        signA = sa; signB = sb; exponentIn = ex;
        alignedMantissaA = ma; alignedMantissaB = mb;
        sticky = stk; shiftOverflow = sov; bypassALU = byp; bypassResult = bres;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(posedge clock); #1;
            lat++;
        end
        check_value("out_valid", {31'd0, out_valid}, 32'd1);
        check_value("latency", lat, want_lat);
        check_value("result", result, want_res);
        check_value("overflow", {31'd0, overflow}, {31'd0, want_ovf});
        repeat (hold) begin
            @(posedge clock); #1;
            check_value("hold_result", result, want_res);
            check_value("hold_valid", {31'd0, out_valid}, 32'd1);
            check_value("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_value("release_valid", {31'd0, out_valid}, 32'd0);
        check_value("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_random(input logic sa, input logic sb, input logic [7:0] ex,
                              input logic [31:0] ma, input logic [31:0] mb, input logic stk,
                              input logic sov, input logic byp, input logic [31:0] bres,
                              input int hold);
        logic [31:0] r;
        logic o;
        int l;
        ref_model(sa, sb, ex, ma, mb, stk | sov, byp, bres, r, o, l);
        run_txn(sa, sb, ex, ma, mb, stk, sov, byp, bres, hold, r, o, l);
    endtask

    initial begin
        logic [31:0] ma, mb, tmp;
        logic [7:0]  ex;
        repeat (3) @(posedge clock);
        #1;
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_result", result, 32'h0);
        check_value("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_txn(1'b0, 1'b0, 8'(BIAS), 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h4000_0000, 1'b0, 3);
        run_txn(1'b0, 1'b1, 8'(BIAS), 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1,
                32'h3F00_0000, 1'b0, 4);
        run_txn(1'b0, 1'b0, 8'h7F, 32'h8000_0180, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h3F80_0002, 1'b0, 3);
        run_txn(1'b0, 1'b0, 8'h7F, 32'h8000_0080, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h3F80_0000, 1'b0, 3);
        run_txn(1'b0, 1'b0, 8'h7F, 32'h8000_0080, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0,
                32'h3F80_0001, 1'b0, 3);
        run_txn(1'b0, 1'b0, 8'hFE, 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h7F80_0000, 1'b1, 3);
        run_txn(1'b0, 1'b0, 8'h10, 32'h1234_5600, 32'h0, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000, 3,
                32'h7FC0_0000, 1'b0, 1);
        run_txn(1'b1, 1'b0, 8'h40, 32'h9000_0000, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h0000_0000, 1'b0, 2);
        run_txn(1'b0, 1'b1, 8'h03, 32'h8000_0000, 32'h7FFF_FF00, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                32'h0000_0004, 1'b0, 5);

        // Reset landing while the block is normalising.
        @(negedge clock);
        signA = 1'b0; signB = 1'b1; exponentIn = 8'h7F;
        alignedMantissaA = 32'h8000_0000; alignedMantissaB = 32'h7FFF_FF00;
        sticky = 1'b0; shiftOverflow = 1'b0; bypassALU = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_value("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_value("midrst_result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_value("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_value("postrst_out_valid", {31'd0, out_valid}, 32'd0);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0:       ex = 8'hFE - 8'($urandom_range(0, 1));
                1:       ex = 8'($urandom_range(1, 4));
                default: ex = 8'($urandom_range(1, 254));
            endcase
            ma = $urandom | 32'h8000_0000;
            mb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) ma[7:0] = 8'h80;
            if ($urandom_range(0, 15) == 0) mb = ma;
            if ($urandom_range(0, 1) == 1) begin
                tmp = ma; ma = mb; mb = tmp;
            end
            run_random(1'($urandom), 1'($urandom), ex, ma, mb,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
